// File: rtl/addr_delay_line_if.sv
// Bus bundle for addr_delay_line: address/enable input side, control, and tap outputs.
// parity_err exists only when ADDR_DELAY_PARITY_EN is defined.
interface addr_delay_line_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int SEL_WIDTH  = 4
);
   logic [ADDR_WIDTH-1:0] addr_in;
   logic                  e_in;
   logic                  hold;
   logic                  flush;
   logic [SEL_WIDTH-1:0]  delay_sel;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic                  e_out;
   logic                  busy;
   logic [SEL_WIDTH-1:0]  cur_delay;
`ifdef ADDR_DELAY_PARITY_EN
   logic                  parity_err;

   modport master (output addr_in, e_in, hold, flush, delay_sel,
                   input  addr_out, e_out, busy, cur_delay, parity_err);
   modport slave  (input  addr_in, e_in, hold, flush, delay_sel,
                   output addr_out, e_out, busy, cur_delay, parity_err);
`else
   modport master (output addr_in, e_in, hold, flush, delay_sel,
                   input  addr_out, e_out, busy, cur_delay);
   modport slave  (input  addr_in, e_in, hold, flush, delay_sel,
                   output addr_out, e_out, busy, cur_delay);
`endif
endinterface

// File: rtl/addr_delay_line.sv
// Run-time selectable 1..MAX_DEPTH cycle delay line for address + enable with hold/flush.
// Optional per-stage even parity and sticky parity_err under ADDR_DELAY_PARITY_EN.
module addr_delay_line #(
   parameter int ADDR_WIDTH    = 11,
   parameter int MAX_DEPTH     = 8,
   parameter int DEFAULT_DELAY = 1
) (
   input  logic              pll_clock,
   input  logic              reset,
   addr_delay_line_if.slave  bus
);
   localparam int SEL_WIDTH = $clog2(MAX_DEPTH + 1);
   typedef logic [SEL_WIDTH-1:0] sel_t;

   // Discrete flops on purpose: no SRL/RAM mapping of the stages.
   (* preserve, shreg_extract = "no", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
   logic [MAX_DEPTH:1][ADDR_WIDTH-1:0] addr_q;
   (* preserve, shreg_extract = "no", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
   logic [MAX_DEPTH:1]                 e_q;
   logic [MAX_DEPTH:1][ADDR_WIDTH-1:0] addr_d;
   logic [MAX_DEPTH:1]                 e_d;
   sel_t                               sel_q, sel_d, sel_clamp;
   logic                               advance;
   logic [ADDR_WIDTH-1:0]              addr_o;
   logic                               e_o, busy_o;

   assign advance = bus.flush | ~bus.hold;

   always_comb begin
      sel_clamp = bus.delay_sel;
      if (bus.delay_sel == '0)
         sel_clamp = sel_t'(1);
      else if (bus.delay_sel > sel_t'(MAX_DEPTH))
         sel_clamp = sel_t'(MAX_DEPTH);
   end

   always_comb begin
      addr_d = addr_q;
      e_d    = e_q;
      if (advance) begin
         for (int k = MAX_DEPTH; k >= 2; k--) begin
            addr_d[k] = addr_q[k-1];
            e_d[k]    = e_q[k-1];
         end
         addr_d[1] = bus.addr_in;
         e_d[1]    = bus.e_in;
      end
      if (bus.flush)
         e_d = '0;
      // Delay may only move while nothing is in flight, so no enable is lost or doubled.
      sel_d = (bus.flush || (!bus.hold && e_q == '0)) ? sel_clamp : sel_q;
   end

   always_ff @(posedge pll_clock or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         e_q    <= '0;
         sel_q  <= sel_t'(DEFAULT_DELAY);
      end else begin
         addr_q <= addr_d;
         e_q    <= e_d;
         sel_q  <= sel_d;
      end
   end

   always_comb begin
      addr_o = '0;
      e_o    = 1'b0;
      busy_o = 1'b0;
      for (int k = 1; k <= MAX_DEPTH; k++) begin
         if (sel_q == sel_t'(k)) begin
            addr_o = addr_q[k];
            e_o    = e_q[k];
         end
         if (sel_t'(k) < sel_q)
            busy_o = busy_o | e_q[k];
      end
   end

   assign bus.addr_out  = addr_o;
   assign bus.e_out     = e_o;
   assign bus.busy      = busy_o;
   assign bus.cur_delay = sel_q;

`ifdef ADDR_DELAY_PARITY_EN
   (* preserve, shreg_extract = "no", altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
   logic [MAX_DEPTH:1] par_q;
   logic [MAX_DEPTH:1] par_d;
   logic               par_o, perr_q, perr_d;

   always_comb begin
      par_d = par_q;
      if (advance) begin
         for (int k = MAX_DEPTH; k >= 2; k--)
            par_d[k] = par_q[k-1];
         par_d[1] = ^bus.addr_in;
      end
      par_o = 1'b0;
      for (int k = 1; k <= MAX_DEPTH; k++)
         if (sel_q == sel_t'(k))
            par_o = par_q[k];
      perr_d = bus.flush ? 1'b0 : (perr_q | (e_o & ((^addr_o) != par_o)));
   end

   always_ff @(posedge pll_clock or posedge reset) begin
      if (reset) begin
         par_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign bus.parity_err = perr_q;
`endif
endmodule
